// File: rtl/gpio_pkg.sv
// Shared register indices, CTRL bit positions, reset constants and byte-enable
// helpers for the memory-mapped GPIO controller.
package gpio_pkg;

    localparam logic [2:0] GPIO_SW_DATA   = 3'd0;
    localparam logic [2:0] GPIO_SW_EDGE   = 3'd1;
    localparam logic [2:0] GPIO_LED_DATA  = 3'd2;
    localparam logic [2:0] GPIO_BLINK_EN  = 3'd3;
    localparam logic [2:0] GPIO_BLINK_DIV = 3'd4;
    localparam logic [2:0] GPIO_CTRL      = 3'd5;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_LED_EN = 1;

    localparam logic [1:0]  CTRL_RESET  = 2'b10;
    localparam logic        PHASE_RESET = 1'b1;
    localparam logic [31:0] RDATA_RESET = 32'h0000_0000;

    // Expand the 4-bit byte-enable into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
        byte_mask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wmask);
        logic [31:0] m;
        m = byte_mask(wmask);
        merge_bytes = (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioning: 2-flop synchroniser, free-running sample tick and
// two-consecutive-sample agreement filter. Also flags bits rising this cycle.
module sw_debounce #(
    parameter int WIDTH           = 24,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_switch,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_tick_cnt;

    logic             w_tick;
    logic [WIDTH-1:0] w_agree;
    logic [WIDTH-1:0] w_stable_nxt;

    // Next stable vector: a bit only moves when this tick's sample matches the last one.
    always_comb begin
        w_tick  = (r_tick_cnt == TICK_LAST);
        w_agree = ~(r_sample ^ r_sync2);
        if (w_tick) begin
            w_stable_nxt = (r_stable & ~w_agree) | (r_sync2 & w_agree);
        end else begin
            w_stable_nxt = r_stable;
        end
    end

    // Synchroniser, tick counter, sample history and stable state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sample   <= '0;
            r_stable   <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= i_switch;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + CW'(1));
            r_sample   <= w_tick ? r_sync2 : r_sample;
            r_stable   <= w_stable_nxt;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_stable_nxt & ~r_stable;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: debounced switches with sticky rising-edge capture and
// interrupt, plus LEDs with a per-LED blink enable driven by a shared divider.
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter int SW_WIDTH        = 24,
    parameter int LED_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int DIV_WIDTH       = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic                 io_sel,
    input  logic [2:0]           addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wmask,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    input  logic [SW_WIDTH-1:0]  switch_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq
);

    logic [SW_WIDTH-1:0]  r_sw_edge;
    logic [LED_WIDTH-1:0] r_led_data;
    logic [LED_WIDTH-1:0] r_blink_en;
    logic [DIV_WIDTH-1:0] r_blink_div;
    logic [DIV_WIDTH-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [1:0]           r_ctrl;
    logic [31:0]          r_rdata;
    logic                 r_rvalid;
    logic [LED_WIDTH-1:0] r_led_out;
    logic                 r_irq;

    logic [SW_WIDTH-1:0]  w_sw_stable;
    logic [SW_WIDTH-1:0]  w_rise;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_div_wr;
    logic [SW_WIDTH-1:0]  w_edge_clr;
    logic [SW_WIDTH-1:0]  w_edge_nxt;
    logic [LED_WIDTH-1:0] w_led_data_nxt;
    logic [LED_WIDTH-1:0] w_blink_en_nxt;
    logic [DIV_WIDTH-1:0] w_blink_div_nxt;
    logic [DIV_WIDTH-1:0] w_blink_cnt_nxt;
    logic                 w_phase_nxt;
    logic [1:0]           w_ctrl_nxt;
    logic [31:0]          w_rd_mux;
    logic [LED_WIDTH-1:0] w_led_out_nxt;
    logic                 w_irq_nxt;

    sw_debounce #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clock    (clock),
        .reset    (reset),
        .i_switch (switch_in),
        .o_stable (w_sw_stable),
        .o_rise   (w_rise)
    );

    // Register writes with byte-enable merge; fields narrower than 32 bits drop upper bits.
    always_comb begin
        w_wr            = io_write & io_sel;
        w_rd            = io_read & io_sel;
        w_div_wr        = 1'b0;
        w_edge_clr      = '0;
        w_led_data_nxt  = r_led_data;
        w_blink_en_nxt  = r_blink_en;
        w_blink_div_nxt = r_blink_div;
        w_ctrl_nxt      = r_ctrl;
        if (w_wr) begin
            case (addr)
                GPIO_SW_EDGE:   w_edge_clr = SW_WIDTH'(byte_mask(wmask) & wdata);
                GPIO_LED_DATA:  w_led_data_nxt = LED_WIDTH'(merge_bytes(32'(r_led_data), wdata, wmask));
                GPIO_BLINK_EN:  w_blink_en_nxt = LED_WIDTH'(merge_bytes(32'(r_blink_en), wdata, wmask));
                GPIO_BLINK_DIV: begin
                    w_blink_div_nxt = DIV_WIDTH'(merge_bytes(32'(r_blink_div), wdata, wmask));
                    w_div_wr        = 1'b1;
                end
                GPIO_CTRL:      w_ctrl_nxt = 2'(merge_bytes(32'(r_ctrl), wdata, wmask));
                default:        w_div_wr = 1'b0;
            endcase
        end else begin
            w_div_wr = 1'b0;
        end
    end

    // Blink divider: a divider write restarts the half-period with the LEDs lit.
    always_comb begin
        if (w_div_wr) begin
            w_blink_cnt_nxt = w_blink_div_nxt;
            w_phase_nxt     = 1'b1;
        end else if (r_blink_div == '0) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b1;
        end else if (r_blink_cnt == '0) begin
            w_blink_cnt_nxt = r_blink_div;
            w_phase_nxt     = ~r_phase;
        end else begin
            w_blink_cnt_nxt = r_blink_cnt - DIV_WIDTH'(1);
            w_phase_nxt     = r_phase;
        end
    end

    // Edge flags (a new edge beats a same-cycle clear) and outputs from next state.
    always_comb begin
        w_edge_nxt    = (r_sw_edge & ~w_edge_clr) | w_rise;
        w_irq_nxt     = w_ctrl_nxt[CTRL_IRQ_EN] & (|w_edge_nxt);
        if (w_ctrl_nxt[CTRL_LED_EN]) begin
            w_led_out_nxt = w_led_data_nxt & ~(w_blink_en_nxt & {LED_WIDTH{~w_phase_nxt}});
        end else begin
            w_led_out_nxt = '0;
        end
    end

    // Read mux of pre-write register state.
    always_comb begin
        case (addr)
            GPIO_SW_DATA:   w_rd_mux = 32'(w_sw_stable);
            GPIO_SW_EDGE:   w_rd_mux = 32'(r_sw_edge);
            GPIO_LED_DATA:  w_rd_mux = 32'(r_led_data);
            GPIO_BLINK_EN:  w_rd_mux = 32'(r_blink_en);
            GPIO_BLINK_DIV: w_rd_mux = 32'(r_blink_div);
            GPIO_CTRL:      w_rd_mux = {30'd0, r_ctrl};
            default:        w_rd_mux = 32'd0;
        endcase
    end

    // All architectural state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_edge   <= '0;
            r_led_data  <= '0;
            r_blink_en  <= '0;
            r_blink_div <= '0;
            r_blink_cnt <= '0;
            r_phase     <= PHASE_RESET;
            r_ctrl      <= CTRL_RESET;
            r_rdata     <= RDATA_RESET;
            r_rvalid    <= 1'b0;
            r_led_out   <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_sw_edge   <= w_edge_nxt;
            r_led_data  <= w_led_data_nxt;
            r_blink_en  <= w_blink_en_nxt;
            r_blink_div <= w_blink_div_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_rdata     <= w_rd ? w_rd_mux : r_rdata;
            r_rvalid    <= w_rd;
            r_led_out   <= w_led_out_nxt;
            r_irq       <= w_irq_nxt;
        end
    end

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign led_out = r_led_out;
    assign irq     = r_irq;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with DEBOUNCE_CYCLES=4 and 24-bit switch/LED ports.
module tb_mmio_gpio;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_read;
    logic        io_write;
    logic        io_sel;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        rvalid;
    logic [23:0] switch_in;
    logic [23:0] led_out;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    mmio_gpio #(
        .SW_WIDTH        (24),
        .LED_WIDTH       (24),
        .DEBOUNCE_CYCLES (4),
        .DIV_WIDTH       (24)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .io_sel    (io_sel),
        .addr      (addr),
        .wdata     (wdata),
        .wmask     (wmask),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .switch_in (switch_in),
        .led_out   (led_out),
        .irq       (irq)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        io_write = 1'b1; io_sel = 1'b1; addr = a; wdata = d; wmask = m;
        step();
        io_write = 1'b0; io_sel = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        io_read = 1'b1; io_sel = 1'b1; addr = a;
        step();
        io_read = 1'b0; io_sel = 1'b0;
        chk(tag, rdata, exp);
        chk({tag, "_rvalid_hi"}, {31'd0, rvalid}, 32'd1);
        step();
        chk({tag, "_rvalid_lo"}, {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; io_read = 1'b0; io_write = 1'b0; io_sel = 1'b0;
        addr = 3'd0; wdata = 32'd0; wmask = 4'd0; switch_in = 24'd0;
        steps(2);
        chk("rst_led", {8'd0, led_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            rd($sformatf("rst_reg%0d", r), 3'(r), (r == 5) ? 32'h0000_0002 : 32'h0000_0000);
        end

        wr(3'd2, 32'h00A5_A5A5, 4'hF);
        chk("led_full_write", {8'd0, led_out}, 32'h00A5_A5A5);
        wr(3'd2, 32'hFFFF_FFFF, 4'h1);
        rd("led_byte0_write", 3'd2, 32'h00A5_A5FF);
        io_read = 1'b1; io_write = 1'b1; io_sel = 1'b1; addr = 3'd2; wdata = 32'h0000_0012; wmask = 4'hF;
        step();
        io_read = 1'b0; io_write = 1'b0; io_sel = 1'b0;
        chk("rw_old_value", rdata, 32'h00A5_A5FF);
        chk("rw_led_out", {8'd0, led_out}, 32'h0000_0012);
        rd("rw_new_value", 3'd2, 32'h0000_0012);
        wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        rd("led_upper_dropped", 3'd2, 32'h00FF_FFFF);

        wr(3'd5, 32'h0000_0003, 4'hF);
        switch_in[3] = 1'b1;
        steps(10);
        chk("irq_after_edge", {31'd0, irq}, 32'd1);
        rd("sw_data_bit3", 3'd0, 32'h0000_0008);
        rd("sw_edge_bit3", 3'd1, 32'h0000_0008);
        wr(3'd1, 32'h0000_0008, 4'hF);
        chk("irq_after_clear", {31'd0, irq}, 32'd0);
        rd("sw_edge_cleared", 3'd1, 32'h0000_0000);

        switch_in[5] = 1'b1;
        steps(3);
        switch_in[5] = 1'b0;
        steps(12);
        rd("glitch_sw_data", 3'd0, 32'h0000_0008);
        rd("glitch_sw_edge", 3'd1, 32'h0000_0000);
        chk("glitch_irq", {31'd0, irq}, 32'd0);

        switch_in[3] = 1'b0;
        steps(12);
        rd("sw_data_fall", 3'd0, 32'h0000_0000);
        rd("fall_no_edge", 3'd1, 32'h0000_0000);
        switch_in[3] = 1'b1;
        io_write = 1'b1; io_sel = 1'b1; addr = 3'd1; wdata = 32'h0000_0008; wmask = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (irq) begin
                seen = 1'b1;
                break;
            end
        end
        io_write = 1'b0; io_sel = 1'b0;
        chk("set_beats_clear_irq", {31'd0, seen}, 32'd1);
        rd("set_beats_clear_edge", 3'd1, 32'h0000_0008);
        wr(3'd1, 32'h0000_0008, 4'h2);
        rd("clear_wrong_byte", 3'd1, 32'h0000_0008);
        wr(3'd1, 32'h0000_0008, 4'h1);
        rd("clear_right_byte", 3'd1, 32'h0000_0000);

        wr(3'd2, 32'h0000_000F, 4'hF);
        wr(3'd3, 32'h0000_0003, 4'hF);
        wr(3'd4, 32'h0000_0005, 4'hF);
        chk("blink_start", {8'd0, led_out}, 32'h0000_000F);
        steps(5);
        chk("blink_on_end", {8'd0, led_out}, 32'h0000_000F);
        step();
        chk("blink_off_start", {8'd0, led_out}, 32'h0000_000C);
        steps(5);
        chk("blink_off_end", {8'd0, led_out}, 32'h0000_000C);
        step();
        chk("blink_on_again", {8'd0, led_out}, 32'h0000_000F);
        wr(3'd5, 32'h0000_0001, 4'hF);
        chk("led_disabled", {8'd0, led_out}, 32'h0000_0000);
        wr(3'd5, 32'h0000_0003, 4'hF);
        wr(3'd4, 32'h0000_0000, 4'hF);
        chk("div0_steady_a", {8'd0, led_out}, 32'h0000_000F);
        steps(7);
        chk("div0_steady_b", {8'd0, led_out}, 32'h0000_000F);
        steps(6);
        chk("div0_steady_c", {8'd0, led_out}, 32'h0000_000F);

        wr(3'd4, 32'h0000_0005, 4'hF);
        switch_in = 24'h00_0088;
        steps(3);
        rd("pre_reset_sw_data", 3'd0, 32'h0000_0008);
        reset = 1'b1;
        step();
        chk("midrst_led", {8'd0, led_out}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        reset = 1'b0;
        rd("post_rst_sw_data", 3'd0, 32'h0000_0000);
        rd("post_rst_sw_edge", 3'd1, 32'h0000_0000);
        rd("post_rst_ctrl", 3'd5, 32'h0000_0002);
        rd("post_rst_led_data", 3'd2, 32'h0000_0000);
        chk("post_rst_led_out", {8'd0, led_out}, 32'd0);
        steps(12);
        rd("redebounce_sw_data", 3'd0, 32'h0000_0088);
        rd("redebounce_sw_edge", 3'd1, 32'h0000_0088);
        chk("redebounce_irq_off", {31'd0, irq}, 32'd0);
        wr(3'd1, 32'hFFFF_FFFF, 4'hF);
        rd("sw_clears_edge", 3'd1, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
